ifetch_queue: RTL

IFETCH_QUEUE -- requirements
Module: ifetch_queue

---
 rtl/legv8_pkg.sv | 20 ++
 rtl/ifq_fifo.sv | 53 +++++
 rtl/ifetch_queue.sv | 121 ++++++++++++
 3 files changed

// File: rtl/legv8_pkg.sv
// Shared definitions for the LEGv8 fetch path: data widths, PC increment,
// fetch FSM encoding and the word-alignment helper.
package legv8_pkg;

    localparam int INST_W  = 32;
    localparam int ADDR_W  = 64;
    localparam int PC_INC  = 4;
    localparam int ENTRY_W = ADDR_W + INST_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } ifq_state_t;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return addr & ~ADDR_W'(3);
    endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Synchronous FIFO holding {pc, instruction} entries for the fetch queue,
// with a single-cycle flush that empties it.
module ifq_fifo
    import legv8_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = ENTRY_W
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is data-only and carries no reset; count gates its visibility.
    always_ff @(posedge clock) begin
        if (push && !flush) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch unit: single-outstanding memory request FSM plus queue.
// Define IFETCH_QUEUE_BYPASS_EN to forward an ack straight to the head when empty.
module ifetch_queue
    import legv8_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 64'h0
) (
    input  logic                    clock,
    input  logic                    reset_n,
    output logic                    imem_req,
    output logic [ADDR_W-1:0]       imem_addr,
    input  logic                    imem_ack,
    input  logic [INST_W-1:0]       imem_rdata,
    input  logic                    redirect_en,
    input  logic [ADDR_W-1:0]       redirect_addr,
    input  logic                    stall,
    output logic                    inst_valid,
    output logic [INST_W-1:0]       inst_out,
    output logic [ADDR_W-1:0]       inst_pc,
    output logic [$clog2(DEPTH):0]  q_count
);

    localparam int              CW       = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);

    ifq_state_t          state;
    ifq_state_t          state_nxt;
    logic [ADDR_W-1:0]   fetch_pc;
    logic [ADDR_W-1:0]   req_addr;
    logic                run;
    logic                full;
    logic                issue;
    logic                accept;
    logic                bypass;
    logic                push;
    logic                pop;
    logic [ENTRY_W-1:0]  head;

    assign full   = (q_count == FULL_CNT);
    // run delays the first request by one cycle after reset release.
    assign issue  = (state == IDLE) && run && !full && !redirect_en;
    assign accept = (state == WAIT) && imem_ack && !redirect_en;

`ifdef IFETCH_QUEUE_BYPASS_EN
    assign bypass = accept && (q_count == '0) && !stall;
`else
    assign bypass = 1'b0;
`endif

    assign push       = accept && !bypass;
    assign pop        = (q_count != '0) && !stall && !redirect_en;
    assign imem_req   = (state != IDLE) || issue;
    assign imem_addr  = (state == IDLE) ? fetch_pc : req_addr;
    assign inst_valid = (q_count != '0) || bypass;

    always_comb begin
        inst_out = '0;
        inst_pc  = '0;
        if (q_count != '0) begin
            inst_out = head[INST_W-1:0];
            inst_pc  = head[ENTRY_W-1:INST_W];
        end
`ifdef IFETCH_QUEUE_BYPASS_EN
        if (bypass) begin
            inst_out = imem_rdata;
            inst_pc  = fetch_pc;
        end
`endif
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (issue) state_nxt = WAIT;
            WAIT: begin
                if (imem_ack)         state_nxt = IDLE;
                else if (redirect_en) state_nxt = DROP;
            end
            DROP:    if (imem_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            run      <= 1'b0;
        end else begin
            run   <= 1'b1;
            state <= state_nxt;
            if (redirect_en)
                fetch_pc <= word_align(redirect_addr);
            else if (accept)
                fetch_pc <= fetch_pc + ADDR_W'(PC_INC);
        end
    end

    // Latched at issue so the address stays put even if fetch_pc is redirected.
    always_ff @(posedge clock) begin
        if (issue) req_addr <= fetch_pc;
    end

    ifq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .flush   (redirect_en),
        .push    (push),
        .pop     (pop),
        .wdata   ({fetch_pc, imem_rdata}),
        .rdata   (head),
        .count   (q_count)
    );

    a_no_push_when_full: assert property (@(posedge clock) disable iff (!reset_n) push |-> !full);

endmodule
